// File: rtl/pcpu_pkg.sv
// rtl/pcpu_pkg.sv - shared CPU types: branch codes, counter encodings, PC step
package pcpu_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_EQ   = 3'b001,
        BR_NE   = 3'b010,
        BR_GEZ  = 3'b011,
        BR_GTZ  = 3'b100,
        BR_LEZ  = 3'b101,
        BR_LTZ  = 3'b110
    } br_code_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
    import pcpu_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_next_o
);

    always_comb begin
        cnt_next_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != 2'(ST)) cnt_next_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != 2'(SNT)) cnt_next_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB predictor with 2-bit counters
module branch_predictor
    import pcpu_pkg::*;
#(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic [31:0] id_pc,
    input  logic        id_taken,
    input  logic [31:0] id_target,
    input  logic        id_pred_taken,
    input  logic [31:0] id_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 32 - IDX_W - 2;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [1:0]       cnt_q    [DEPTH];

    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, upd;
    logic [1:0]       cnt_next;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], id_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign lk_idx      = if_pc[IDX_W+1:2];
    assign lk_tag      = if_pc[31:IDX_W+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && cnt_q[lk_idx][1];
    assign pred_target = pred_taken ? target_q[lk_idx] : next_seq_pc(if_pc);

    assign upd         = id_valid && !id_stall;
    assign mispredict  = upd && ((id_taken != id_pred_taken) ||
                                 (id_taken && (id_pred_target != id_target)));
    assign redirect_pc = id_taken ? id_target : next_seq_pc(id_pc);

    assign up_idx = id_pc[IDX_W+1:2];
    assign up_tag = id_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    sat_counter2 u_sat_counter2 (
        .cnt_i      (cnt_q[up_idx]),
        .taken_i    (id_taken),
        .cnt_next_o (cnt_next)
    );

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (upd && (stat_branches_q != 32'hFFFF_FFFF))
            stat_branches_d = stat_branches_q + 32'd1;
        if (mispredict && (stat_mispred_q != 32'hFFFF_FFFF))
            stat_mispred_d = stat_mispred_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
            if (upd) begin
                if (up_hit) begin
                    cnt_q[up_idx] <= cnt_next;
                    if (id_taken) target_q[up_idx] <= id_target;
                end else if (id_taken) begin
                    // Taken miss evicts whatever occupies the slot.
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= id_target;
                    cnt_q[up_idx]    <= 2'(WT);
                end
            end
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vectors plus randomized reference-model check
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid, id_stall, id_taken, id_pred_taken;
    logic [31:0] id_pc, id_target, id_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc, stat_branches, stat_mispred;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .id_valid       (id_valid),
        .id_stall       (id_stall),
        .id_pc          (id_pc),
        .id_taken       (id_taken),
        .id_target      (id_target),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        v, s;
        logic [31:0] ipc;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_red;
        logic [31:0] e_br, e_mp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [31:0] pc, logic v, logic s, logic [31:0] ipc,
                                logic tk, logic [31:0] tgt, logic ptk, logic [31:0] ptgt,
                                logic e_pt, logic [31:0] e_ptgt, logic e_mis, logic [31:0] e_red,
                                logic [31:0] e_br, logic [31:0] e_mp);
        vec_t r;
        r.rst = rst; r.pc = pc; r.v = v; r.s = s; r.ipc = ipc; r.tk = tk; r.tgt = tgt;
        r.ptk = ptk; r.ptgt = ptgt; r.e_pt = e_pt; r.e_ptgt = e_ptgt; r.e_mis = e_mis;
        r.e_red = e_red; r.e_br = e_br; r.e_mp = e_mp;
        return r;
    endfunction

    // Reference model: one slot per index, keyed by the full PC stored there.
    bit          m_valid [16];
    int unsigned m_pc    [16];
    int unsigned m_tgt   [16];
    int          m_cnt   [16];
    longint      m_br, m_mp;

    function automatic int slot(int unsigned pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit m_hit(int unsigned pc);
        int k = slot(pc);
        return m_valid[k] && ((m_pc[k] / 64) == (pc / 64));
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 16; k++) begin
            m_valid[k] = 0; m_cnt[k] = 1; m_pc[k] = 0; m_tgt[k] = 0;
        end
        m_br = 0; m_mp = 0;
    endtask

    initial begin
        vec_t x;
        bit   e_pt, e_mis, upd;
        int unsigned e_ptgt, e_red;
        int   k;

        reset = 1'b1; if_pc = 32'h0040_0010; id_valid = 0; id_stall = 0; id_pc = 0;
        id_taken = 0; id_target = 0; id_pred_taken = 0; id_pred_target = 0;
        repeat (2) @(posedge clk);

        vecs.push_back(mk(0, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 0,
                          0, 32'h0040_0014, 0, 32'hx, 0, 0));
        vecs.push_back(mk(0, 32'h0040_0010, 1, 0, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0040_0014,
                          0, 32'h0040_0014, 1, 32'h0040_0100, 0, 0));
        vecs.push_back(mk(0, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 0,
                          1, 32'h0040_0100, 0, 32'hx, 1, 1));
        vecs.push_back(mk(0, 32'h0040_0010, 1, 0, 32'h0040_0010, 1, 32'h0040_0100, 1, 32'h0040_0100,
                          1, 32'h0040_0100, 0, 32'hx, 1, 1));
        vecs.push_back(mk(0, 32'h0040_0010, 1, 0, 32'h0040_0010, 1, 32'h0040_0100, 1, 32'h0040_0100,
                          1, 32'h0040_0100, 0, 32'hx, 2, 1));
        vecs.push_back(mk(0, 32'h0040_0010, 1, 0, 32'h0040_0010, 0, 32'h0040_0100, 1, 32'h0040_0100,
                          1, 32'h0040_0100, 1, 32'h0040_0014, 3, 1));
        vecs.push_back(mk(0, 32'h0040_0010, 1, 1, 32'h0040_0010, 0, 32'h0040_0100, 1, 32'h0040_0100,
                          1, 32'h0040_0100, 0, 32'hx, 4, 2));
        vecs.push_back(mk(0, 32'h0040_0010, 1, 0, 32'h0040_0050, 1, 32'h0040_0200, 0, 32'h0040_0054,
                          1, 32'h0040_0100, 1, 32'h0040_0200, 4, 2));
        vecs.push_back(mk(0, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 0,
                          0, 32'h0040_0014, 0, 32'hx, 5, 3));
        vecs.push_back(mk(0, 32'h0040_0050, 0, 0, 0, 0, 0, 0, 0,
                          1, 32'h0040_0200, 0, 32'hx, 5, 3));
        vecs.push_back(mk(1, 32'h0040_0050, 1, 0, 32'h0040_0090, 1, 32'h0040_0300, 0, 32'h0040_0094,
                          1, 32'h0040_0200, 1, 32'h0040_0300, 5, 3));
        vecs.push_back(mk(0, 32'h0040_0050, 0, 0, 0, 0, 0, 0, 0,
                          0, 32'h0040_0054, 0, 32'hx, 0, 0));
        vecs.push_back(mk(0, 32'h0040_0090, 0, 0, 0, 0, 0, 0, 0,
                          0, 32'h0040_0094, 0, 32'hx, 0, 0));
        vecs.push_back(mk(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0,
                          0, 32'h0000_0000, 0, 32'hx, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            x = vecs[i];
            @(posedge clk); #1;
            reset = x.rst; if_pc = x.pc; id_valid = x.v; id_stall = x.s; id_pc = x.ipc;
            id_taken = x.tk; id_target = x.tgt; id_pred_taken = x.ptk; id_pred_target = x.ptgt;
            #3;
            chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(x.e_pt));
            chk($sformatf("v%0d pred_target", i), pred_target, x.e_ptgt);
            chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(x.e_mis));
            if (x.e_mis) chk($sformatf("v%0d redirect_pc", i), redirect_pc, x.e_red);
            chk($sformatf("v%0d stat_branches", i), stat_branches, x.e_br);
            chk($sformatf("v%0d stat_mispred", i), stat_mispred, x.e_mp);
        end

        // Randomized phase against the reference model.
        @(posedge clk); #1;
        reset = 1'b1; id_valid = 0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset    = ($urandom_range(0, 199) == 0);
            if_pc    = 32'h0040_0000 + 32'($urandom_range(0, 2)) * 32'h40 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 19) == 0) if_pc = $urandom;
            id_valid = ($urandom_range(0, 3) != 0);
            id_stall = ($urandom_range(0, 5) == 0);
            id_pc    = 32'h0040_0000 + 32'($urandom_range(0, 2)) * 32'h40 + 32'($urandom_range(0, 15)) * 4;
            id_taken = $urandom_range(0, 1);
            id_target = {$urandom_range(0, 255), 2'b00} + 32'h0050_0000;
            k = slot(id_pc);
            if ($urandom_range(0, 1)) begin
                id_pred_taken  = m_hit(id_pc) && (m_cnt[k] >= 2);
                id_pred_target = id_pred_taken ? m_tgt[k] : id_pc + 4;
            end else begin
                id_pred_taken  = $urandom_range(0, 1);
                id_pred_target = $urandom_range(0, 1) ? id_target : id_pc + 4;
            end
            #3;
            k      = slot(if_pc);
            e_pt   = m_hit(if_pc) && (m_cnt[k] >= 2);
            e_ptgt = e_pt ? m_tgt[k] : if_pc + 4;
            upd    = id_valid && !id_stall;
            e_mis  = upd && ((id_taken != id_pred_taken) || (id_taken && id_pred_target != id_target));
            e_red  = id_taken ? id_target : id_pc + 4;
            chk("rnd pred_taken", 32'(pred_taken), 32'(e_pt));
            chk("rnd pred_target", pred_target, e_ptgt);
            chk("rnd mispredict", 32'(mispredict), 32'(e_mis));
            if (e_mis) chk("rnd redirect_pc", redirect_pc, e_red);
            chk("rnd stat_branches", stat_branches, 32'(m_br));
            chk("rnd stat_mispred", stat_mispred, 32'(m_mp));

            if (reset) begin
                m_reset();
            end else if (upd) begin
                k = slot(id_pc);
                m_br = (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
                if (e_mis) m_mp = (m_mp < 64'hFFFF_FFFF) ? m_mp + 1 : m_mp;
                if (m_hit(id_pc)) begin
                    if (id_taken) begin
                        m_cnt[k] = (m_cnt[k] + 1 > 3) ? 3 : m_cnt[k] + 1;
                        m_tgt[k] = id_target;
                    end else begin
                        m_cnt[k] = (m_cnt[k] - 1 < 0) ? 0 : m_cnt[k] - 1;
                    end
                end else if (id_taken) begin
                    m_valid[k] = 1; m_pc[k] = id_pc; m_tgt[k] = id_target; m_cnt[k] = 2;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage pipelined CPU.
- Predicts direction and target for the fetch PC in IF.
- Consumes the branch resolution produced in ID (the resolved Branch code and Branch_flag) to train itself, detect mispredictions, and issue a redirect/flush to the PC logic.
- Direct-mapped BTB with a 2-bit saturating counter per entry.

Parameters:
- IDX_W, 4, index bits; table depth = 2**IDX_W entries.
- CNT_INIT, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_pc  in  32  fetch-stage PC.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  32  next fetch PC: BTB target if predicted taken, else if_pc+4.
- id_valid  in  1  ID stage holds a branch (Branch code != 3'b000) this cycle.
- id_stall  in  1  ID stage stalled; resolution not final.
- id_pc  in  32  PC of the branch in ID.
- id_taken  in  1  resolved direction (Branch_flag).
- id_target  in  32  computed branch target.
- id_pred_taken  in  1  prediction carried down the pipe with the branch.
- id_pred_target  in  32  predicted next PC carried down the pipe.
- mispredict  out  1  redirect required this cycle.
- redirect_pc  out  32  correct next PC: id_target if id_taken, else id_pc+4.
- stat_branches  out  32  resolved branch count.
- stat_mispred  out  32  mispredict count.

Behaviour:
- Entry fields: valid, tag (32-IDX_W-2 bits), target (32), cnt (2).
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
- Lookup (IF, combinational, zero latency):
  - hit = valid & tag match.
  - pred_taken = hit & cnt[1].
  - pred_target = pred_taken ? entry.target : if_pc+4 (32-bit wrap).
- Resolve (ID, combinational): upd = id_valid & ~id_stall.
  - mispredict = upd & ((id_taken != id_pred_taken) | (id_taken & (id_pred_target != id_target))).
  - redirect_pc is valid only while mispredict=1.
- Update (registered, takes effect the clock edge after upd):
  - Hit, taken: cnt = min(cnt+1, 3); target overwritten with id_target.
  - Hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss, taken: allocate (overwrite any occupant): valid=1, tag, target=id_target, cnt=2'b10.
  - Miss, not taken: no allocation, table unchanged.
- Statistics:
  - stat_branches increments on every upd.
  - stat_mispred increments on upd & mispredict.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents. No bypass. The new value is visible the next cycle.
- id_stall=1: no update, no stat change, mispredict=0, even if id_valid=1.
- Reset (synchronous, active-high, highest priority):
  - All valid=0, all cnt=CNT_INIT, stats=0.
  - An update presented in the reset cycle is discarded.
  - Combinational outputs after reset: pred_taken=0, pred_target=if_pc+4, mispredict follows inputs.
- Reset mid-operation: table is fully cleared in one cycle; no partial state survives.
- Prediction uses only the BTB. Entries are never invalidated except by reset.

Decomposition:
- Shared package pcpu_pkg:
  - Branch condition codes (BR_NONE=3'b000, BR_EQ=3'b001, BR_NE=3'b010, BR_GEZ=3'b011, BR_GTZ=3'b100, BR_LEZ=3'b101, BR_LTZ=3'b110).
  - 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11).
  - PC_STEP=4.
- One sub-module: sat_counter2, a combinational next-state function (cnt, taken -> cnt_next), instanced once in the update path.

Test Plan:
- Reset then if_pc=32'h0040_0010 -> pred_taken=0, pred_target=32'h0040_0014; both stats 0.
- Branch at 32'h0040_0010 resolved taken, target 32'h0040_0100, predicted not-taken -> mispredict=1, redirect_pc=32'h0040_0100. Next cycle lookup of same PC -> pred_taken=1, pred_target=32'h0040_0100.
- Same branch taken twice more, then not taken once -> cnt 10->11->11->10; the fourth lookup still predicts taken; the not-taken resolve gives mispredict=1, redirect_pc=32'h0040_0014.
- Aliasing: 32'h0040_0010 and 32'h0040_0050 share index 4 with different tags. Taken on the second PC evicts the first -> lookup of 32'h0040_0010 returns hit=0, pred_target=32'h0040_0014.
- Stall and same-cycle conflict:
  - id_valid=1 with id_stall=1 -> no mispredict, stats and table unchanged.
  - Lookup and update on the same index in the same cycle -> old prediction returned that cycle, new one the cycle after.
- Reset asserted mid-run with an update pending -> all entries invalid, stats 0, pending update discarded. pc=32'hFFFF_FFFC predicts 32'h0000_0000 (wrap).
